alu_flag_reg: RTL

Registered Z80 flag unit (F and shadow F') with per-op-class flag update rules.
Generalises the combinational status logic to 8- or 16-bit operands, corrects subtract overflow, and adds EX AF,AF' swap, POP AF load, SCF/CCF and condition-code evaluation.
Sits beside the ALU datapath. The CPU control FSM drives the class and strobes; the branch logic consumes cc_true.

---
 rtl/alu_flag_pkg.sv | 59 +++++
 rtl/alu_flag_calc.sv | 154 +++++++++++++++
 rtl/alu_flag_reg.sv | 116 +++++++++++
 3 files changed

// File: rtl/alu_flag_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_flag_pkg
//  Description : Shared types for the Z80 flag unit. Defines the op-class and
//                condition-code encodings, the flag bit positions within F,
//                and the even-parity helper.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_flag_pkg;

  // Flag-update class driven by the CPU control FSM alongside op_valid.
  typedef enum logic [3:0] {
    FC_NONE  = 4'd0,
    FC_ADD   = 4'd1,
    FC_SUB   = 4'd2,
    FC_CMP   = 4'd3,
    FC_AND   = 4'd4,
    FC_OR    = 4'd5,
    FC_XOR   = 4'd6,
    FC_INC   = 4'd7,
    FC_DEC   = 4'd8,
    FC_ROTA  = 4'd9,
    FC_SHIFT = 4'd10,
    FC_BIT   = 4'd11,
    FC_ADD16 = 4'd12,
    FC_SCF   = 4'd13,
    FC_CCF   = 4'd14,
    FC_CPL   = 4'd15
  } flag_class_e;

  // Condition codes in Z80 instruction-encoding order.
  typedef enum logic [2:0] {
    CC_NZ = 3'd0,
    CC_Z  = 3'd1,
    CC_NC = 3'd2,
    CC_C  = 3'd3,
    CC_PO = 3'd4,
    CC_PE = 3'd5,
    CC_P  = 3'd6,
    CC_M  = 3'd7
  } cond_e;

  // Bit positions within the F register.
  localparam int FLAG_S = 7;
  localparam int FLAG_Z = 6;
  localparam int FLAG_Y = 5;
  localparam int FLAG_H = 4;
  localparam int FLAG_X = 3;
  localparam int FLAG_P = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 0;

  // Z80 parity flag convention: 1 when the byte has an even number of ones.
  function automatic logic parity_even(input logic [7:0] v);
    return ~(^v);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_flag_calc.sv
`default_nettype none
// ============================================================================
//  Module      : alu_flag_calc
//  Description : Combinational next-F computation for one ALU op class.
//                Bits not touched by the class are taken from f_i.
//  Ports       : op_class_i  flag_class_e encoding
//                a_i, b_i    ALU operands (b unmodified)
//                result_i    ALU result
//                carry_in_i  carry into the ALU
//                carry_out_i ALU carry/borrow out or shifted-out bit
//                f_i         current F
//                f_o         F after applying the class rules
//  Options     : ALU_FLAG_UNDOC_XY_EN - copy undocumented Y/X bits from the
//                result (or from a for SCF/CCF/CPL); otherwise force them 0.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_flag_calc
  import alu_flag_pkg::*;
#(
  parameter int ALU_WIDTH = 8
) (
  input  logic [3:0]           op_class_i,
  input  logic [ALU_WIDTH-1:0] a_i,
  input  logic [ALU_WIDTH-1:0] b_i,
  input  logic [ALU_WIDTH-1:0] result_i,
  input  logic                 carry_in_i,
  input  logic                 carry_out_i,
  input  logic [7:0]           f_i,
  output logic [7:0]           f_o
);

  // Half-carry boundary: nibble at 8 bits, bit 11->12 at 16 bits.
  localparam int HALF_BITS = ALU_WIDTH - 4;
  localparam int MSB       = ALU_WIDTH - 1;

  flag_class_e w_cls;
  assign w_cls = flag_class_e'(op_class_i);

  // INC/DEC reuse the add/sub half-carry and overflow terms with b forced to 1
  // and no carry in, so the caller need not drive b for them.
  logic                 w_incdec;
  logic [ALU_WIDTH-1:0] w_b;
  logic                 w_cin;
  assign w_incdec = (w_cls == FC_INC) || (w_cls == FC_DEC);
  assign w_b      = w_incdec ? ALU_WIDTH'(1) : b_i;
  assign w_cin    = w_incdec ? 1'b0 : carry_in_i;

  // One extra bit on the low slice captures the carry / borrow out of it;
  // the subtract wraps so its top bit is set exactly when a borrow occurs.
  logic [HALF_BITS:0] w_hadd;
  logic [HALF_BITS:0] w_hsub;
  assign w_hadd = {1'b0, a_i[HALF_BITS-1:0]} + {1'b0, w_b[HALF_BITS-1:0]}
                + {{HALF_BITS{1'b0}}, w_cin};
  assign w_hsub = {1'b0, a_i[HALF_BITS-1:0]} - {1'b0, w_b[HALF_BITS-1:0]}
                - {{HALF_BITS{1'b0}}, w_cin};

  logic w_s, w_z, w_par, w_vadd, w_vsub;
  assign w_s    = result_i[MSB];
  assign w_z    = (result_i == '0);
  assign w_par  = parity_even(result_i[7:0]);
  assign w_vadd = (a_i[MSB] == w_b[MSB]) && (result_i[MSB] != a_i[MSB]);
  assign w_vsub = (a_i[MSB] != w_b[MSB]) && (result_i[MSB] != a_i[MSB]);

  logic w_y, w_x;
`ifdef ALU_FLAG_UNDOC_XY_EN
  logic [ALU_WIDTH-1:0] w_xy_src;
  assign w_xy_src = ((w_cls == FC_SCF) || (w_cls == FC_CCF) || (w_cls == FC_CPL))
                    ? a_i : result_i;
  assign w_y = w_xy_src[ALU_WIDTH-3];
  assign w_x = w_xy_src[ALU_WIDTH-5];
`else
  assign w_y = 1'b0;
  assign w_x = 1'b0;
`endif

  // Operand bits that only feed some widths/builds are gathered here.
  logic w_unused_bits;
  assign w_unused_bits = ^{a_i, w_b, w_hadd[HALF_BITS-1:0], w_hsub[HALF_BITS-1:0]};

  always_comb begin
    f_o = f_i;
    case (w_cls)
      FC_ADD: begin
        f_o[FLAG_S] = w_s;           f_o[FLAG_Z] = w_z;
        f_o[FLAG_H] = w_hadd[HALF_BITS];
        f_o[FLAG_P] = w_vadd;        f_o[FLAG_N] = 1'b0;
        f_o[FLAG_C] = carry_out_i;
      end
      FC_SUB, FC_CMP: begin
        f_o[FLAG_S] = w_s;           f_o[FLAG_Z] = w_z;
        f_o[FLAG_H] = w_hsub[HALF_BITS];
        f_o[FLAG_P] = w_vsub;        f_o[FLAG_N] = 1'b1;
        f_o[FLAG_C] = carry_out_i;
      end
      FC_AND: begin
        f_o[FLAG_S] = w_s;           f_o[FLAG_Z] = w_z;
        f_o[FLAG_H] = 1'b1;          f_o[FLAG_P] = w_par;
        f_o[FLAG_N] = 1'b0;          f_o[FLAG_C] = 1'b0;
      end
      FC_OR, FC_XOR: begin
        f_o[FLAG_S] = w_s;           f_o[FLAG_Z] = w_z;
        f_o[FLAG_H] = 1'b0;          f_o[FLAG_P] = w_par;
        f_o[FLAG_N] = 1'b0;          f_o[FLAG_C] = 1'b0;
      end
      FC_INC: begin
        f_o[FLAG_S] = w_s;           f_o[FLAG_Z] = w_z;
        f_o[FLAG_H] = w_hadd[HALF_BITS];
        f_o[FLAG_P] = w_vadd;        f_o[FLAG_N] = 1'b0;
      end
      FC_DEC: begin
        f_o[FLAG_S] = w_s;           f_o[FLAG_Z] = w_z;
        f_o[FLAG_H] = w_hsub[HALF_BITS];
        f_o[FLAG_P] = w_vsub;        f_o[FLAG_N] = 1'b1;
      end
      // Accumulator rotates and 16-bit adds leave S, Z and P/V alone.
      FC_ROTA: begin
        f_o[FLAG_H] = 1'b0;          f_o[FLAG_N] = 1'b0;
        f_o[FLAG_C] = carry_out_i;
      end
      FC_ADD16: begin
        f_o[FLAG_H] = w_hadd[HALF_BITS];
        f_o[FLAG_N] = 1'b0;          f_o[FLAG_C] = carry_out_i;
      end
      FC_SHIFT: begin
        f_o[FLAG_S] = w_s;           f_o[FLAG_Z] = w_z;
        f_o[FLAG_P] = w_par;         f_o[FLAG_H] = 1'b0;
        f_o[FLAG_N] = 1'b0;          f_o[FLAG_C] = carry_out_i;
      end
      FC_BIT: begin
        f_o[FLAG_S] = w_s;           f_o[FLAG_Z] = w_z;
        f_o[FLAG_P] = w_z;           f_o[FLAG_H] = 1'b1;
        f_o[FLAG_N] = 1'b0;
      end
      FC_SCF: begin
        f_o[FLAG_H] = 1'b0;          f_o[FLAG_N] = 1'b0;
        f_o[FLAG_C] = 1'b1;
      end
      FC_CCF: begin
        f_o[FLAG_H] = f_i[FLAG_C];   f_o[FLAG_N] = 1'b0;
        f_o[FLAG_C] = ~f_i[FLAG_C];
      end
      FC_CPL: begin
        f_o[FLAG_H] = 1'b1;          f_o[FLAG_N] = 1'b1;
      end
      default: f_o = f_i;
    endcase
    if (w_cls != FC_NONE) begin
      f_o[FLAG_Y] = w_y;
      f_o[FLAG_X] = w_x;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_flag_reg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_flag_reg
//  Description : Registered Z80 flag unit: active F and shadow F', strobe
//                priority (ld_f > ex_af > op_valid), conflict pulse and
//                condition-code evaluation.
//  Ports       : clk, reset      clock / synchronous active-high reset
//                op_valid        apply op_class flag update
//                op_class        flag_class_e encoding
//                a, b, op_result ALU operands and result (ALU_WIDTH bits)
//                carry_in        ALU carry in
//                carry_out       ALU carry/borrow out or shifted-out bit
//                ld_f, f_din     load F (POP AF)
//                ex_af           swap F and F'
//                cc_sel          condition select (cond_e)
//                f_q             active F
//                cc_true         cc_sel evaluated against f_q
//                conflict        one-cycle pulse when 2+ strobes collided
//  Options     : ALU_FLAG_UNDOC_XY_EN (see alu_flag_calc)
//  Parameters  : ALU_WIDTH - 8 or 16
//  Revision    : 1.0  initial release
// ============================================================================
module alu_flag_reg
  import alu_flag_pkg::*;
#(
  parameter int ALU_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 op_valid,
  input  logic [3:0]           op_class,
  input  logic [ALU_WIDTH-1:0] a,
  input  logic [ALU_WIDTH-1:0] b,
  input  logic [ALU_WIDTH-1:0] op_result,
  input  logic                 carry_in,
  input  logic                 carry_out,
  input  logic                 ld_f,
  input  logic [7:0]           f_din,
  input  logic                 ex_af,
  input  logic [2:0]           cc_sel,
  output logic [7:0]           f_q,
  output logic                 cc_true,
  output logic                 conflict
);

  logic [7:0] f_d;
  logic [7:0] f_alt_q;
  logic [7:0] f_alt_d;
  logic       conflict_d;
  logic [7:0] w_f_calc;

  alu_flag_calc #(
    .ALU_WIDTH (ALU_WIDTH)
  ) u_calc (
    .op_class_i  (op_class),
    .a_i         (a),
    .b_i         (b),
    .result_i    (op_result),
    .carry_in_i  (carry_in),
    .carry_out_i (carry_out),
    .f_i         (f_q),
    .f_o         (w_f_calc)
  );

  // A NONE op is a no-op strobe and must not register as a collision.
  logic       w_op_act;
  logic [1:0] w_nstrobe;
  assign w_op_act  = op_valid && (op_class != FC_NONE);
  assign w_nstrobe = {1'b0, ld_f} + {1'b0, ex_af} + {1'b0, w_op_act};

  always_comb begin
    f_d        = f_q;
    f_alt_d    = f_alt_q;
    conflict_d = (w_nstrobe >= 2'd2);
    if (ld_f) begin
      f_d = f_din;
    end else if (ex_af) begin
      f_d     = f_alt_q;
      f_alt_d = f_q;
    end else if (op_valid) begin
      f_d = w_f_calc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_q      <= 8'h00;
      f_alt_q  <= 8'h00;
      conflict <= 1'b0;
    end else begin
      f_q      <= f_d;
      f_alt_q  <= f_alt_d;
      conflict <= conflict_d;
    end
  end

  cond_e w_cond;
  assign w_cond = cond_e'(cc_sel);

  always_comb begin
    cc_true = 1'b0;
    case (w_cond)
      CC_NZ:   cc_true = ~f_q[FLAG_Z];
      CC_Z:    cc_true =  f_q[FLAG_Z];
      CC_NC:   cc_true = ~f_q[FLAG_C];
      CC_C:    cc_true =  f_q[FLAG_C];
      CC_PO:   cc_true = ~f_q[FLAG_P];
      CC_PE:   cc_true =  f_q[FLAG_P];
      CC_P:    cc_true = ~f_q[FLAG_S];
      CC_M:    cc_true =  f_q[FLAG_S];
      default: cc_true = 1'b0;
    endcase
  end

endmodule
`default_nettype wire
